boot_controller: RTL and testbench
==================================

BOOT_CONTROLLER -- requirements
Module: boot_controller

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: maximum number of instruction words that may be loaded.
REQ-002 Parameter HOLD_CYCLES, default 4: number of cycles cpu_rst is held after the last write.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 load_valid  input  1  load_data/load_last are valid this cycle.
REQ-007 load_data  input  32  instruction word.
REQ-008 load_last  input  1  marks the final word of the program.
REQ-009 load_ready  output  1  controller accepts a word this cycle.
REQ-010 initialize  output  1  instruction-memory write strobe; also forces the fetched instruction to 32'hFFFF_FFFF.
REQ-011 instruction_initialize_data  output  32  word to write.
REQ-012 instruction_initialize_address  output  32  byte address to write.
REQ-013 cpu_rst  output  1  reset to the CPU program counter.
REQ-014 busy  output  1  high in LOAD or HOLD.
REQ-015 error  output  1  overflow flag.
REQ-016 word_count  output  clog2(DEPTH_WORDS)+1  number of words accepted in the current load.

Function
REQ-017 The states SHALL be IDLE, LOAD, HOLD, RUN and ERR.
REQ-018 A beat SHALL be accepted when load_valid and load_ready are both high.
REQ-019 load_ready SHALL be high only in LOAD, decoded from the state register.
REQ-020 IDLE SHALL hold cpu_rst=1 and SHALL transition to LOAD on start, clearing word_count and error.
REQ-021 Each accepted beat with word_count<DEPTH_WORDS SHALL produce the following in the next cycle:
- initialize=1 for exactly one cycle;
- instruction_initialize_data = the accepted word;
- instruction_initialize_address = 4*word_count (pre-increment value).
REQ-022 word_count SHALL increment on each such accepted beat.
REQ-023 initialize SHALL be 0 in every cycle not following an accepted beat.
REQ-024 Data and address SHALL retain their last values when no beat is accepted.
REQ-025 An accepted beat with load_last=1 SHALL be written per REQ-021, and the next state SHALL be HOLD.
REQ-026 If an accepted beat arrives with word_count==DEPTH_WORDS, it SHALL be discarded (no initialize strobe), error SHALL become 1, and the next state SHALL be ERR.
REQ-027 A last beat arriving at word_count==DEPTH_WORDS-1 SHALL be a legal fill, not an error.
REQ-028 HOLD SHALL keep cpu_rst=1 for exactly HOLD_CYCLES cycles, then transition to RUN.
REQ-029 RUN SHALL drive cpu_rst=0.
REQ-030 start received in RUN SHALL transition to LOAD, with cpu_rst=1 from the next cycle.
REQ-031 ERR SHALL hold cpu_rst=1 and error=1 until start (transition to LOAD, error cleared) or rst.
REQ-032 start SHALL be ignored in LOAD and HOLD.
REQ-033 load_valid SHALL be ignored outside LOAD.
REQ-034 cpu_rst SHALL be 1 in every state except RUN.

Reset
REQ-035 On rst the following SHALL apply:
- state=IDLE;
- cpu_rst=1;
- initialize=0, load_ready=0, busy=0, error=0;
- word_count=0, instruction_initialize_data=0, instruction_initialize_address=0;
- HOLD counter cleared.
REQ-036 rst asserted during LOAD or HOLD SHALL abort the load with no further initialize strobe; a strobe pending from the cycle before rst SHALL be suppressed.

Structure
REQ-037 The state encoding and the default values of DEPTH_WORDS and HOLD_CYCLES SHALL reside in shared package boot_pkg.
REQ-038 The HOLD timer SHALL be one sub-module, cycle_counter: synchronous clear, enable, terminal-count output.
REQ-039 All outputs except load_ready and busy SHALL be registered.

Verification
REQ-040 Basic load: rst, start, 3 beats 0x20010005/0x20020007/0x00221820 (last on 3rd) -> strobes at addresses 0, 4, 8 with matching data; word_count=3; cpu_rst falls exactly 4 cycles after the last strobe.
REQ-041 Backpressure gaps: load_valid toggled 1-0-0-1 -> one strobe per accepted beat only; no strobes during gap cycles; addresses contiguous.
REQ-042 Overflow with DEPTH_WORDS=4: 5 beats, none marked last -> 4 strobes (addresses 0..12); 5th beat discarded; error=1; cpu_rst=1 held; subsequent start clears error.
REQ-043 Exact fill with DEPTH_WORDS=4: 4 beats, last on 4th -> no error; HOLD then RUN.
REQ-044 Reload from RUN: start -> cpu_rst=1 next cycle; word_count=0; first new strobe at address 0.
REQ-045 Reset mid-load: rst on the cycle after the 2nd beat is accepted -> no strobe for that beat; all outputs at reset values; state=IDLE.

Source files
------------

// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and default sizing for the boot controller.
package boot_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;
   localparam int DEPTH_WORDS_DEF = 64;
   localparam int HOLD_CYCLES_DEF = 4;
endpackage

// File: rtl/cycle_counter.sv
// cycle_counter: clearable, enabled up-counter with terminal count at N-1.
module cycle_counter #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int W = $clog2(N + 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   end
   assign tc = cnt == W'(N - 1);
endmodule

// File: rtl/boot_controller.sv
// boot_controller: streams a program into instruction memory, then releases the CPU reset.
module boot_controller import boot_pkg::*; #(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          load_valid,
   input  logic [31:0]                   load_data,
   input  logic                          load_last,
   output logic                          load_ready,
   output logic                          initialize,
   output logic [31:0]                   instruction_initialize_data,
   output logic [31:0]                   instruction_initialize_address,
   output logic                          cpu_rst,
   output logic                          busy,
   output logic                          error,
   output logic [$clog2(DEPTH_WORDS):0]  word_count
);
   localparam int CW = $clog2(DEPTH_WORDS) + 1;
   state_t state, state_n;
   logic accept, full, write, start_load, hold_done, init_q;
   assign load_ready = state == LOAD;
   assign busy       = state == LOAD || state == HOLD;
   assign accept     = load_valid && load_ready;
   assign full       = word_count == CW'(DEPTH_WORDS);
   assign write      = accept && !full;
   assign start_load = state != LOAD && state_n == LOAD;
   // A strobe registered just before reset must not reach memory during the reset cycle
   assign initialize = init_q && !rst;
   cycle_counter #(.N(HOLD_CYCLES)) u_hold (
      .clk(clk),
      .clr(rst || state != HOLD),
      .en (state == HOLD),
      .tc (hold_done)
   );
   always_comb begin
      state_n = state;
      case (state)
         IDLE, RUN, ERR: state_n = start ? LOAD : state;
         LOAD:           state_n = !accept ? LOAD : full ? ERR : load_last ? HOLD : LOAD;
         HOLD:           state_n = hold_done ? RUN : HOLD;
         default:        state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state                          <= IDLE;
         cpu_rst                        <= 1'b1;
         init_q                         <= 1'b0;
         error                          <= 1'b0;
         word_count                     <= '0;
         instruction_initialize_data    <= '0;
         instruction_initialize_address <= '0;
      end else begin
         state   <= state_n;
         cpu_rst <= state_n != RUN;
         init_q  <= write;
         if (start_load) begin
            word_count <= '0;
            error      <= 1'b0;
         end
         if (write) begin
            word_count                     <= word_count + 1'b1;
            instruction_initialize_data    <= load_data;
            instruction_initialize_address <= 32'({word_count, 2'b00});
         end
         if (accept && full) error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_boot_controller.sv
// tb_boot_controller: directed stimulus checked every cycle against a behavioural model.
module tb_boot_controller;
   localparam int DEPTH = 4;
   localparam int HOLDC = 4;
   localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3, P_ERR = 4;
   logic clk = 1'b0;
   logic rst, start, load_valid, load_last;
   logic [31:0] load_data;
   logic load_ready, initialize, cpu_rst, busy, error;
   logic [31:0] idata, iaddr;
   logic [2:0] word_count;
   boot_controller #(.DEPTH_WORDS(DEPTH), .HOLD_CYCLES(HOLDC)) dut (
      .clk(clk), .rst(rst), .start(start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
      .initialize(initialize), .instruction_initialize_data(idata),
      .instruction_initialize_address(iaddr), .cpu_rst(cpu_rst), .busy(busy),
      .error(error), .word_count(word_count)
   );
   always #5 clk = ~clk;
   int m_phase, m_count, m_hold_left;
   logic m_init, m_err, m_cpu_rst;
   logic [31:0] m_data, m_addr;
   always @(posedge clk) begin
      if (rst) begin
         m_phase = P_IDLE; m_count = 0; m_err = 0; m_init = 0;
         m_data = 0; m_addr = 0; m_hold_left = 0;
      end else begin
         m_init = 0;
         if (m_phase == P_LOAD) begin
            if (load_valid) begin
               if (m_count == DEPTH) begin
                  m_err = 1; m_phase = P_ERR;
               end else begin
                  m_init = 1; m_data = load_data; m_addr = 32'(4 * m_count);
                  m_count++;
                  if (load_last) begin
                     m_phase = P_HOLD; m_hold_left = HOLDC;
                  end
               end
            end
         end else if (m_phase == P_HOLD) begin
            m_hold_left--;
            if (m_hold_left == 0) m_phase = P_RUN;
         end else if (start) begin
            m_phase = P_LOAD; m_count = 0; m_err = 0;
         end
      end
      m_cpu_rst = m_phase != P_RUN;
   end
   int n_cmp = 0, n_bad = 0, cy = 0, last_strobe = -1, fall_cy = -1;
   logic prev_cpu_rst = 1'b1;
   logic [31:0] s_addr[$], s_data[$];
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   task automatic cyc(input logic s, input logic v, input logic l, input logic [31:0] d, input logic r);
      logic [71:0] got, exp;
      start = s; load_valid = v; load_last = l; load_data = d; rst = r;
      @(negedge clk);
      got = {initialize, load_ready, busy, cpu_rst, error, word_count, idata, iaddr};
      exp = {m_init && !rst, m_phase == P_LOAD, m_phase == P_LOAD || m_phase == P_HOLD,
             m_cpu_rst, m_err, 3'(m_count), m_data, m_addr};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL cycle %0d outputs: got %h expected %h", cy, got, exp);
      end
      if (initialize) begin
         s_addr.push_back(iaddr); s_data.push_back(idata); last_strobe = cy;
      end
      if (prev_cpu_rst && !cpu_rst) fall_cy = cy;
      prev_cpu_rst = cpu_rst;
      cy++;
      @(posedge clk); #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0);
   endtask
   task automatic clear_log();
      s_addr.delete(); s_data.delete();
   endtask
   initial begin
      rst = 1; start = 0; load_valid = 0; load_last = 0; load_data = 0;
      @(posedge clk); #1;
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk("reset cpu_rst", 32'(cpu_rst), 1);
      chk("reset word_count", 32'(word_count), 0);
      chk("reset busy/ready/error/init", {28'h0, busy, load_ready, error, initialize}, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 32'h20010005, 0);
      cyc(0, 1, 0, 32'h20020007, 0);
      cyc(0, 1, 1, 32'h00221820, 0);
      cyc(1, 1, 0, 32'hDEAD0000, 0);
      idle(7);
      chk("basic strobes", s_addr.size(), 3);
      chk("basic addr1", s_addr[1], 32'd4);
      chk("basic addr2", s_addr[2], 32'd8);
      chk("basic data0", s_data[0], 32'h20010005);
      chk("basic data2", s_data[2], 32'h00221820);
      chk("basic word_count", 32'(word_count), 3);
      chk("basic release delay", fall_cy - last_strobe, 4);
      cyc(0, 1, 1, 32'hBAD0BAD0, 0);
      clear_log();
      cyc(1, 0, 0, 0, 0);
      chk("reload cpu_rst", 32'(cpu_rst), 1);
      chk("reload word_count", 32'(word_count), 0);
      cyc(0, 1, 0, 32'h11111111, 0);
      cyc(0, 0, 0, 32'h22222222, 0);
      cyc(0, 0, 0, 32'h33333333, 0);
      cyc(0, 1, 1, 32'h44444444, 0);
      idle(8);
      chk("gap strobes", s_addr.size(), 2);
      chk("gap addr0", s_addr[0], 0);
      chk("gap addr1", s_addr[1], 32'd4);
      chk("gap data1", s_data[1], 32'h44444444);
      chk("gap run", 32'(cpu_rst), 0);
      clear_log();
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'hA000_0000 + 32'(i), 0);
      idle(3);
      chk("ovf strobes", s_addr.size(), 4);
      chk("ovf addr3", s_addr[3], 32'd12);
      chk("ovf error", 32'(error), 1);
      chk("ovf cpu_rst", 32'(cpu_rst), 1);
      cyc(1, 0, 0, 0, 0);
      chk("ovf error cleared", 32'(error), 0);
      clear_log();
      for (int i = 0; i < 4; i++) cyc(0, 1, i == 3, 32'hB000_0000 + 32'(i), 0);
      idle(8);
      chk("fill strobes", s_addr.size(), 4);
      chk("fill error", 32'(error), 0);
      chk("fill run", 32'(cpu_rst), 0);
      clear_log();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 32'hC0000001, 0);
      cyc(0, 1, 0, 32'hC0000002, 0);
      cyc(0, 0, 0, 0, 1);
      chk("midrst strobes", s_addr.size(), 1);
      chk("midrst word_count", 32'(word_count), 0);
      chk("midrst data", idata, 0);
      chk("midrst addr", iaddr, 0);
      chk("midrst flags", {28'h0, busy, load_ready, error, initialize}, 0);
      chk("midrst cpu_rst", 32'(cpu_rst), 1);
      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
